// File: rtl/msx_bus_sync_if.sv
// Cartridge-edge bundle for msx_bus_sync.
// Carries the raw Z80 bus inputs, the registered cycle outputs presented to the slot and
// device logic, the device read response and the cartridge data-bus drive.
//   slave  : the view msx_bus_sync takes (bus and device response in; cycle and drive out)
//   master : the opposite view, for whatever drives the bus and consumes the cycle
interface msx_bus_sync_if;
    // Raw cartridge edge (asynchronous to clk)
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_in;
    logic        bus_rd_n;
    logic        bus_wr_n;
    logic        bus_mreq_n;
    logic        bus_iorq_n;
    logic        bus_sltsl_n;
    // Registered cycle presented to slot/device logic
    logic [15:0] addr;
    logic [7:0]  cdin;
    logic        rd_n;
    logic        wr_n;
    logic        sltsl_n;
    logic        iorq_n;
    logic        enable;
    // Device read response
    logic        dev_busreq;
    logic [7:0]  dev_cdout;
    // Cartridge data-bus drive
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;

    modport slave (
        input  bus_addr, bus_data_in, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n, bus_sltsl_n,
        input  dev_busreq, dev_cdout,
        output addr, cdin, rd_n, wr_n, sltsl_n, iorq_n, enable,
        output bus_data_out, bus_data_oe
    );

    modport master (
        output bus_addr, bus_data_in, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n, bus_sltsl_n,
        output dev_busreq, dev_cdout,
        input  addr, cdin, rd_n, wr_n, sltsl_n, iorq_n, enable,
        input  bus_data_out, bus_data_oe
    );
endinterface

// File: rtl/msx_bus_sync.sv
// MSX cartridge-edge front end.
// Synchronises the asynchronous Z80 bus into clk, detects the start of each memory or I/O
// cycle, presents a registered address/data/strobe set with a one-cycle enable pulse, and
// drives the device read response onto the cartridge data bus until the host ends the read.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      msx_bus_sync_if.slave: raw bus in, registered cycle out, device response in,
//            cartridge data drive out
module msx_bus_sync #(
    parameter int unsigned SYNC_STAGES  = 2,  // >= 2
    parameter int unsigned RESP_TIMEOUT = 6   // 1..15
) (
    input logic           clk,
    input logic           reset_n,
    msx_bus_sync_if.slave bus
);

    // Packed synchroniser word: {addr, data, rd_n, wr_n, mreq_n, iorq_n, sltsl_n}
    localparam int unsigned SyncW = 29;
    // Strobes reset to their active level so a cycle already in progress when reset
    // releases never looks like a fresh falling edge.
    localparam logic [SyncW-1:0] SyncRst = {16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [3:0] TimeoutLast = 4'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitResp,
        StDrive,
        StHold
    } state_e;

    logic [SyncW-1:0] sync_q [SYNC_STAGES];
    logic [SyncW-1:0] bus_in;

    logic [15:0] s_addr;
    logic [7:0]  s_data;
    logic        s_rd_n, s_wr_n, s_mreq_n, s_iorq_n, s_sltsl_n;
    logic        strb_s;
    logic        cyc_start;

    state_e      state_q;
    logic        strb_prev_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q;
    logic [7:0]  cdin_q;
    logic        rd_n_q, wr_n_q, sltsl_n_q, iorq_n_q;
    logic        enable_q;
    logic [7:0]  data_out_q;
    logic        oe_q;

    assign bus_in = {bus.bus_addr, bus.bus_data_in, bus.bus_rd_n, bus.bus_wr_n,
                     bus.bus_mreq_n, bus.bus_iorq_n, bus.bus_sltsl_n};

    // Every input, address and data included, goes through the same depth so they stay
    // aligned with the strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= SyncRst;
            end
        end else begin
            sync_q[0] <= bus_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign {s_addr, s_data, s_rd_n, s_wr_n, s_mreq_n, s_iorq_n, s_sltsl_n} =
        sync_q[SYNC_STAGES-1];

    assign strb_s = s_rd_n & s_wr_n;

    // Falling edge of (rd_n & wr_n) with exactly one strobe low and a request active.
    // Refresh (mreq low, strobes high) never produces the edge.
    assign cyc_start = strb_prev_q & ~strb_s & (s_rd_n | s_wr_n) & (~s_mreq_n | ~s_iorq_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            strb_prev_q <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            cdin_q      <= '0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            sltsl_n_q   <= 1'b1;
            iorq_n_q    <= 1'b1;
            enable_q    <= 1'b0;
            data_out_q  <= '0;
            oe_q        <= 1'b0;
        end else begin
            strb_prev_q <= strb_s;
            enable_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cyc_start) begin
                        addr_q    <= s_addr;
                        cdin_q    <= s_data;
                        rd_n_q    <= s_rd_n;
                        wr_n_q    <= s_wr_n;
                        iorq_n_q  <= s_iorq_n;
                        // Slot select only qualifies memory cycles
                        sltsl_n_q <= s_sltsl_n | s_mreq_n;
                        enable_q  <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= !rd_n_q ? StWaitResp : StHold;
                end
                StWaitResp: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (s_rd_n) begin
                        // Host abandoned the read before any device answered
                        rd_n_q    <= 1'b1;
                        wr_n_q    <= 1'b1;
                        sltsl_n_q <= 1'b1;
                        iorq_n_q  <= 1'b1;
                        state_q   <= StIdle;
                    end else if (bus.dev_busreq) begin
                        data_out_q <= bus.dev_cdout;
                        oe_q       <= 1'b1;
                        state_q    <= StDrive;
                    end else if (cnt_q == TimeoutLast) begin
                        state_q <= StHold;
                    end
                end
                StDrive: begin
                    if (s_rd_n) begin
                        oe_q      <= 1'b0;
                        rd_n_q    <= 1'b1;
                        wr_n_q    <= 1'b1;
                        sltsl_n_q <= 1'b1;
                        iorq_n_q  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StHold: begin
                    if (strb_s) begin
                        rd_n_q    <= 1'b1;
                        wr_n_q    <= 1'b1;
                        sltsl_n_q <= 1'b1;
                        iorq_n_q  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.addr         = addr_q;
    assign bus.cdin         = cdin_q;
    assign bus.rd_n         = rd_n_q;
    assign bus.wr_n         = wr_n_q;
    assign bus.sltsl_n      = sltsl_n_q;
    assign bus.iorq_n       = iorq_n_q;
    assign bus.enable       = enable_q;
    assign bus.bus_data_out = data_out_q;
    assign bus.bus_data_oe  = oe_q;

endmodule

// File: tb/tb_msx_bus_sync.sv
// Self-checking bench for msx_bus_sync: directed cases for reset, write, claimed and
// unclaimed reads, I/O, refresh and reset during drive, then randomized bus cycles checked
// against a transaction-level model of the expected enable/latch/drive timing.
module tb_msx_bus_sync;

    localparam int S  = 2;
    localparam int RT = 6;

    localparam int KMemWr   = 0;
    localparam int KMemRd   = 1;
    localparam int KIoRd    = 2;
    localparam int KIoWr    = 3;
    localparam int KRefresh = 4;
    localparam int KBoth    = 5;
    localparam int KNoReq   = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Model of the last latched cycle (addr/cdin persist across IDLE)
    logic [15:0] m_addr = 16'h0000;
    logic [7:0]  m_cdin = 8'h00;

    msx_bus_sync_if bif ();

    msx_bus_sync #(
        .SYNC_STAGES (S),
        .RESP_TIMEOUT(RT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bif.bus_rd_n    = 1'b1;
        bif.bus_wr_n    = 1'b1;
        bif.bus_mreq_n  = 1'b1;
        bif.bus_iorq_n  = 1'b1;
        bif.bus_sltsl_n = 1'b1;
    endtask

    task automatic drive_kind(input int kind, input logic [15:0] a, input logic [7:0] d,
                              input logic sl);
        bif.bus_addr    = a;
        bif.bus_data_in = d;
        bif.bus_sltsl_n = sl;
        bif.bus_mreq_n  = !(kind == KMemWr || kind == KMemRd || kind == KRefresh ||
                            kind == KBoth);
        bif.bus_iorq_n  = !(kind == KIoRd || kind == KIoWr);
        bif.bus_rd_n    = !(kind == KMemRd || kind == KIoRd || kind == KBoth ||
                            kind == KNoReq);
        bif.bus_wr_n    = !(kind == KMemWr || kind == KIoWr || kind == KBoth);
    endtask

    function automatic logic [63:0] reset_view();
        return 64'({bif.addr, bif.cdin, bif.rd_n, bif.wr_n, bif.sltsl_n, bif.iorq_n,
                    bif.enable, bif.bus_data_out, bif.bus_data_oe});
    endfunction

    localparam logic [38:0] ResetVals = {16'h0, 8'h0, 4'hF, 1'b0, 8'h0, 1'b0};

    // One bus cycle. claim_d: ticks after enable at which busreq is pulsed (0 = never).
    task automatic run_cycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                             input logic sl, input int claim_d, input int hold,
                             input logic [7:0] rv);
        int          e_t, n_en, first_oe, last_oe, rel_t, total;
        logic        exp_valid, exp_rd, exp_mem, exp_io, exp_claim;
        logic [3:0]  exp_str, cap_str, cur_str;
        logic [15:0] cap_addr;
        logic [7:0]  cap_cdin;
        logic        unstable, bad_data, idle_entry_ok;

        exp_valid = (kind == KMemWr || kind == KMemRd || kind == KIoRd || kind == KIoWr);
        exp_rd    = (kind == KMemRd || kind == KIoRd);
        exp_mem   = (kind == KMemWr || kind == KMemRd);
        exp_io    = (kind == KIoRd || kind == KIoWr);
        exp_claim = exp_rd && claim_d >= 1 && claim_d <= RT;
        exp_str   = {!exp_rd, exp_rd, exp_mem ? sl : 1'b1, !exp_io};

        rel_t = S + 3 + claim_d + hold;
        total = rel_t + S + 4;
        e_t = -1; n_en = 0; first_oe = -1; last_oe = -1;
        unstable = 1'b0; bad_data = 1'b0; idle_entry_ok = 1'b0;
        cap_str = '0; cap_addr = '0; cap_cdin = '0;

        bif.dev_busreq = 1'b0;
        bif.dev_cdout  = ~rv;
        drive_kind(kind, a, d, sl);

        for (int t = 1; t <= total; t++) begin
            tick();
            cur_str = {bif.rd_n, bif.wr_n, bif.sltsl_n, bif.iorq_n};
            if (bif.enable) begin
                n_en++;
                if (e_t < 0) begin
                    e_t = t;
                    cap_str = cur_str;
                    cap_addr = bif.addr;
                    cap_cdin = bif.cdin;
                end
            end
            if (e_t >= 0 && t > e_t && t <= rel_t + S &&
                {cur_str, bif.addr, bif.cdin} != {cap_str, cap_addr, cap_cdin})
                unstable = 1'b1;
            if (t == rel_t + S + 1) idle_entry_ok = (cur_str == 4'hF);
            if (bif.bus_data_oe) begin
                if (first_oe < 0) first_oe = t;
                last_oe = t;
                if (bif.bus_data_out !== rv) bad_data = 1'b1;
            end
            bif.dev_busreq = 1'b0;
            bif.dev_cdout  = ~rv;
            if (claim_d > 0 && e_t >= 0 && t == e_t + claim_d) begin
                bif.dev_busreq = 1'b1;
                bif.dev_cdout  = rv;
            end
            if (t == rel_t) set_idle();
        end

        check_eq("en_count", 64'(n_en), exp_valid ? 64'd1 : 64'd0);
        if (exp_valid) begin
            m_addr = a;
            m_cdin = d;
            check_eq("en_latency", 64'(e_t), 64'(S + 1));
            check_eq("addr", 64'(cap_addr), 64'(a));
            check_eq("cdin", 64'(cap_cdin), 64'(d));
            check_eq("strobes", 64'(cap_str), 64'(exp_str));
            check_eq("stable", 64'(unstable), 64'd0);
            check_eq("idle_entry", 64'(idle_entry_ok), 64'd1);
        end
        if (exp_claim) begin
            check_eq("oe_rise", 64'(first_oe), 64'(S + 2 + claim_d));
            check_eq("oe_data", 64'(bad_data), 64'd0);
            check_eq("oe_fall", 64'(last_oe >= rel_t && last_oe <= rel_t + S), 64'd1);
        end else begin
            check_eq("no_oe", 64'(first_oe), 64'(-1));
        end
        check_eq("idle_str", 64'({bif.rd_n, bif.wr_n, bif.sltsl_n, bif.iorq_n, bif.enable}),
                 64'(5'b11110));
        check_eq("addr_keep", 64'({bif.addr, bif.cdin}), 64'({m_addr, m_cdin}));
    endtask

    initial begin
        int n_en;
        int kind, cd, r;
        logic seen;

        // Reset held with a memory read active on the bus
        bif.dev_busreq = 1'b0;
        bif.dev_cdout  = 8'h00;
        drive_kind(KMemRd, 16'hBEEF, 8'h3C, 1'b0);
        reset_n = 1'b0;
        repeat (4) tick();
        check_eq("reset_vals", reset_view(), 64'(ResetVals));
        reset_n = 1'b1;
        n_en = 0;
        repeat (10) begin
            tick();
            if (bif.enable) n_en++;
        end
        check_eq("no_en_after_reset", 64'(n_en), 64'd0);
        set_idle();
        repeat (S + 3) tick();

        // Directed cases
        run_cycle(KMemWr, 16'hFFFF, 8'hA5, 1'b0, 0, 2, 8'h00);
        run_cycle(KMemRd, 16'hFFFF, 8'h11, 1'b0, 1, 3, 8'h5A);
        run_cycle(KMemRd, 16'h4000, 8'h22, 1'b0, 0, 10, 8'h77);
        run_cycle(KMemRd, 16'h4000, 8'h23, 1'b0, RT + 2, 2, 8'h78);
        run_cycle(KIoRd, 16'h0098, 8'h44, 1'b0, 0, 3, 8'h00);
        run_cycle(KRefresh, 16'h1234, 8'h55, 1'b0, 0, 3, 8'h00);
        run_cycle(KBoth, 16'h2345, 8'h66, 1'b0, 0, 3, 8'h00);
        run_cycle(KNoReq, 16'h3456, 8'h77, 1'b0, 0, 3, 8'h00);

        // Randomized cycles
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 6));
            cd = 0;
            if (kind == KMemRd || kind == KIoRd) begin
                r = int'($urandom_range(0, 2));
                if (r == 1) cd = int'($urandom_range(1, RT - 1));
                if (r == 2) cd = int'($urandom_range(RT + 2, RT + 4));
            end
            run_cycle(kind, 16'($urandom), 8'($urandom), 1'($urandom), cd,
                      int'($urandom_range(1, 8)), 8'($urandom));
        end

        // Reset while driving
        bif.dev_busreq = 1'b0;
        drive_kind(KMemRd, 16'h8001, 8'h0F, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 12 && !seen; t++) begin
            tick();
            seen = bif.enable;
        end
        check_eq("md_enable_seen", 64'(seen), 64'd1);
        tick();
        bif.dev_busreq = 1'b1;
        bif.dev_cdout  = 8'hC3;
        tick();
        bif.dev_busreq = 1'b0;
        check_eq("md_oe_on", 64'({bif.bus_data_oe, bif.bus_data_out}), 64'({1'b1, 8'hC3}));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("md_oe_async_clear", 64'(bif.bus_data_oe), 64'd0);
        check_eq("md_reset_vals", reset_view(), 64'(ResetVals));
        m_addr = 16'h0000;
        m_cdin = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
        n_en = 0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bif.enable) n_en++;
            if (bif.bus_data_oe) seen = 1'b1;
        end
        check_eq("md_quiet_after", 64'({n_en[3:0], seen}), 64'd0);
        set_idle();
        repeat (S + 3) tick();
        run_cycle(KMemWr, 16'h7FFE, 8'h81, 1'b0, 0, 2, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msx_bus_sync.md
Name: msx_bus_sync

Overview:
- Front-end stage between the MSX cartridge edge and the slot/device logic (expanded-slot register, mappers).
- Synchronises asynchronous Z80 bus strobes into clk and detects the start of each memory or I/O cycle.
- Presents a stable, registered address/data/strobe set with a one-cycle enable pulse.
- Collects the device read response (busreq + cdout) and drives the cartridge data bus until the host ends the read.

Parameters:
- SYNC_STAGES, 2, flip-flop depth on every bus input (min 2).
- RESP_TIMEOUT, 6, clk cycles after enable to wait for dev_busreq before abandoning a read (1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bus_addr  in  16  cartridge address A15..A0
- bus_data_in  in  8  cartridge data bus, input side
- bus_rd_n  in  1  Z80 RD_n
- bus_wr_n  in  1  Z80 WR_n
- bus_mreq_n  in  1  Z80 MREQ_n
- bus_iorq_n  in  1  Z80 IORQ_n
- bus_sltsl_n  in  1  slot select for this cartridge
- addr  out  16  registered cycle address
- cdin  out  8  registered write data
- rd_n  out  1  registered read strobe
- wr_n  out  1  registered write strobe
- sltsl_n  out  1  registered slot select (memory cycles only)
- iorq_n  out  1  registered I/O request
- enable  out  1  one-cycle pulse marking a new bus cycle
- dev_busreq  in  1  device claims the read (one cycle is enough)
- dev_cdout  in  8  device read data, valid while dev_busreq=1
- bus_data_out  out  8  data driven to cartridge bus
- bus_data_oe  out  1  cartridge data bus output enable

Behaviour:
- All bus inputs pass through SYNC_STAGES registers. Addr/data use the same depth, so they stay aligned with the strobes.
- Cycle start is the cycle where the synchronised (rd_n & wr_n) goes from 1 to 0 with (mreq_n=0 or iorq_n=0).
- Reset values: addr=0, cdin=0, rd_n=1, wr_n=1, sltsl_n=1, iorq_n=1, enable=0, bus_data_out=0, bus_data_oe=0. State=IDLE.
- bus_data_oe clears asynchronously on reset, including mid-drive.
- IDLE:
  - On cycle start, latch the synchronised addr, data, rd_n, wr_n and iorq_n into the outputs.
  - sltsl_n output = synced bus_sltsl_n OR NOT mreq (forced 1 for I/O cycles).
  - Go to ISSUE.
- Ignored in IDLE, no enable:
  - rd_n=0 and wr_n=0 together (invalid).
  - Refresh: mreq_n=0 with both strobes high.
  - Strobe low with neither mreq_n nor iorq_n low.
- ISSUE: enable=1 for exactly this cycle; outputs are already valid in this cycle. Next state: WAITRESP if read, HOLD if write.
- WAITRESP:
  - Counter starts at 0 and increments each cycle.
  - dev_busreq=1: latch dev_cdout into bus_data_out, set bus_data_oe=1 from the next cycle, go to DRIVE.
  - Counter reaches RESP_TIMEOUT with no busreq: go to HOLD without driving.
  - Synced rd_n returns high first: go to IDLE without driving.
- DRIVE: hold bus_data_out and oe until synced rd_n=1. Then clear oe in the same edge and go to IDLE.
- HOLD: wait until synced rd_n=1 and wr_n=1, then go to IDLE.
- addr/cdin/rd_n/wr_n/sltsl_n/iorq_n stay constant from ISSUE until IDLE is re-entered. On IDLE entry, rd_n, wr_n, sltsl_n and iorq_n return to 1; addr and cdin keep their last values.
- dev_busreq outside WAITRESP is ignored.
- Only one enable per bus cycle; a new cycle is recognised only after a return to IDLE and a fresh falling edge.
- Total latency, bus strobe fall to enable: SYNC_STAGES+1 clk. busreq to oe: 1 clk.

Test Plan:
- Reset: hold reset_n=0 with bus strobes active -> all outputs at reset values. Release -> no enable until a fresh strobe edge.
- Memory write: A=FFFFh, D=A5h, sltsl_n=0, mreq_n=0, wr_n falls -> exactly one enable, SYNC_STAGES+1 clk after the fall, with addr=FFFFh, cdin=A5h, wr_n=0, sltsl_n=0. No oe. Outputs idle after wr_n rises.
- Memory read claimed: A=FFFFh read; dev_busreq=1 with dev_cdout=5Ah one clk after enable -> next clk oe=1 and bus_data_out=5Ah, held until rd_n rises. oe=0 within SYNC_STAGES+1 clk of the rise.
- Read unclaimed: read of 4000h with no busreq -> oe never asserts. After 6 clk the block sits in HOLD and returns to IDLE on rd_n high.
- I/O and refresh: iorq_n=0 with rd_n=0 at port 98h -> enable with iorq_n=0 and sltsl_n=1. Refresh (mreq_n=0, strobes high) -> no enable.
- Reset mid-drive: assert reset_n=0 while oe=1 -> oe=0 immediately, without waiting for a clock edge. State=IDLE after release.
